// File: rtl/sifive_assert_monitor.sv
// sifive_assert_monitor
//
// Watches a set of independent check channels and records failures. Each
// channel reports a compare failure when it is enabled, not waived, and its
// two operands differ. It reports a liveness failure when a request has been
// left unacknowledged for TIMEOUT cycles. Every failure ORs into a per-channel
// sticky flag and is added to a saturating total. The first failure since
// reset or clear is recorded together with its operands. Reaching MAX_FAILS
// raises a sticky halt request.
//
// Ports
//   clock        sole clock, rising edge
//   reset_n      synchronous active-low reset; overrides clear and events
//   chk_valid    per-channel compare enable
//   chk_bypass   per-channel compare waiver
//   chk_a/chk_b  packed operands, channel i at [i*WIDTH +: WIDTH]
//   live_req     per-channel outstanding request
//   live_ack     per-channel acknowledge
//   clear        synchronous clear of all recorded state; discards events
//   fail_sticky  per-channel sticky failure flags
//   fail_count   saturating total failure count
//   first_valid  a first-failure record is held
//   first_ch     channel of the first failure (lowest index on a tie)
//   first_kind   0 = compare failure, 1 = timeout
//   first_a/b    operands at the first failure (zero for a timeout)
//   halt         sticky stop request
module sifive_assert_monitor #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_FAILS = 1,
    parameter int CNT_W     = 8
) (
    input  logic                                               clock,
    input  logic                                               reset_n,
    input  logic [CHANNELS-1:0]                                chk_valid,
    input  logic [CHANNELS-1:0]                                chk_bypass,
    input  logic [CHANNELS*WIDTH-1:0]                          chk_a,
    input  logic [CHANNELS*WIDTH-1:0]                          chk_b,
    input  logic [CHANNELS-1:0]                                live_req,
    input  logic [CHANNELS-1:0]                                live_ack,
    input  logic                                               clear,
    output logic [CHANNELS-1:0]                                fail_sticky,
    output logic [CNT_W-1:0]                                   fail_count,
    output logic                                               first_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_ch,
    output logic                                               first_kind,
    output logic [WIDTH-1:0]                                   first_a,
    output logic [WIDTH-1:0]                                   first_b,
    output logic                                               halt
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int POP_W = $clog2(CHANNELS + 1);
    localparam int SUM_W = CNT_W + POP_W + 1;

    logic [CHANNELS-1:0] cmp_p0;
    logic [CHANNELS-1:0] tmo_p0;
    logic [CHANNELS-1:0] evt_p0;
    logic                hit_any_p0;
    logic [CH_W-1:0]     hit_ch_p0;
    logic                hit_kind_p0;
    logic [WIDTH-1:0]    hit_a_p0;
    logic [WIDTH-1:0]    hit_b_p0;
    logic [CNT_W-1:0]    cnt_next_p0;
    logic                halt_set_p0;

    function automatic logic [POP_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Adds without wrapping: the total sticks at all-ones once reached.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [POP_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    // ---- stage p0: per-channel compare checks ----
    always_comb begin
        cmp_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp_p0[i] = chk_valid[i] & ~chk_bypass[i] &
                        (chk_a[i*WIDTH +: WIDTH] != chk_b[i*WIDTH +: WIDTH]);
        end
    end

    // ---- stage p0: per-channel liveness timers ----
    generate
        if (TIMEOUT > 0) begin : g_live
            for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
                logic [TMO_W-1:0] wait_cnt;

                // Counter parks at TIMEOUT so a held request fires only once
                // until it is released or acknowledged.
                always_ff @(posedge clock) begin
                    if (!reset_n || clear || !live_req[i] || live_ack[i]) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != TMO_W'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                    end
                end

                assign tmo_p0[i] = live_req[i] & ~live_ack[i] &
                                   (wait_cnt == TMO_W'(TIMEOUT - 1));
            end
        end else begin : g_no_live
            assign tmo_p0 = '0;
        end
    endgenerate

    // ---- stage p0: event merge, first-failure select, count update ----
    always_comb begin
        evt_p0      = cmp_p0 | tmo_p0;
        hit_any_p0  = |evt_p0;
        hit_ch_p0   = '0;
        hit_kind_p0 = 1'b0;
        hit_a_p0    = '0;
        hit_b_p0    = '0;
        // Scan from the top so the lowest-index event is the one that sticks.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (evt_p0[i]) begin
                hit_ch_p0   = CH_W'(i);
                hit_kind_p0 = ~cmp_p0[i];
                hit_a_p0    = cmp_p0[i] ? chk_a[i*WIDTH +: WIDTH] : '0;
                hit_b_p0    = cmp_p0[i] ? chk_b[i*WIDTH +: WIDTH] : '0;
            end
        end
        cnt_next_p0 = sat_add(fail_count, popcount(evt_p0));
        halt_set_p0 = (MAX_FAILS > 0) && (32'(cnt_next_p0) >= MAX_FAILS);
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            fail_sticky <= '0;
            fail_count  <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
            first_kind  <= 1'b0;
            first_a     <= '0;
            first_b     <= '0;
            halt        <= 1'b0;
        end else begin
            fail_sticky <= fail_sticky | evt_p0;
            fail_count  <= cnt_next_p0;
            if (halt_set_p0) begin
                halt <= 1'b1;
            end
            if (!first_valid && hit_any_p0) begin
                first_valid <= 1'b1;
                first_ch    <= hit_ch_p0;
                first_kind  <= hit_kind_p0;
                first_a     <= hit_a_p0;
                first_b     <= hit_b_p0;
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-side notice on the halt rising edge; only active when the
    // environment defines the print/stop condition macros.
    logic halt_seen;
    always_ff @(posedge clock) begin
        halt_seen <= halt;
        if (halt && !halt_seen) begin
`ifdef PRINTF_COND
            $display("sifive_assert_monitor: halt, fail_count=%0d first_ch=%0d",
                     fail_count, first_ch);
`endif
`ifdef STOP_COND
            $fatal(1, "sifive_assert_monitor: halt requested");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_sifive_assert_monitor.sv
// Bench for sifive_assert_monitor: two instances share one stimulus stream
// (8-bit count with MAX_FAILS=1, and 2-bit count with MAX_FAILS=3). A
// behavioural model tracks the expected outputs from the failure rules and
// every output is compared each cycle; directed scenarios add literal checks.
module tb_sifive_assert_monitor;

    localparam int CH     = 4;
    localparam int W      = 8;
    localparam int TMO    = 16;
    localparam int CNT_A  = 8;
    localparam int MAXF_A = 1;
    localparam int CNT_B  = 2;
    localparam int MAXF_B = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n;
    logic [CH-1:0]     chk_valid, chk_bypass, live_req, live_ack;
    logic [CH*W-1:0]   chk_a, chk_b;
    logic              clear;

    logic [CH-1:0]     sticky_a, sticky_b;
    logic [CNT_A-1:0]  count_a;
    logic [CNT_B-1:0]  count_b;
    logic              fv_a, fv_b, kind_a, kind_b, halt_a, halt_b;
    logic [1:0]        fch_a, fch_b;
    logic [W-1:0]      fa_a, fb_a, fa_b, fb_b;

    sifive_assert_monitor #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TMO),
                            .MAX_FAILS(MAXF_A), .CNT_W(CNT_A)) dut_a (
        .clock(clock), .reset_n(reset_n), .chk_valid(chk_valid), .chk_bypass(chk_bypass),
        .chk_a(chk_a), .chk_b(chk_b), .live_req(live_req), .live_ack(live_ack),
        .clear(clear), .fail_sticky(sticky_a), .fail_count(count_a), .first_valid(fv_a),
        .first_ch(fch_a), .first_kind(kind_a), .first_a(fa_a), .first_b(fb_a), .halt(halt_a)
    );

    sifive_assert_monitor #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TMO),
                            .MAX_FAILS(MAXF_B), .CNT_W(CNT_B)) dut_b (
        .clock(clock), .reset_n(reset_n), .chk_valid(chk_valid), .chk_bypass(chk_bypass),
        .chk_a(chk_a), .chk_b(chk_b), .live_req(live_req), .live_ack(live_ack),
        .clear(clear), .fail_sticky(sticky_b), .fail_count(count_b), .first_valid(fv_b),
        .first_ch(fch_b), .first_kind(kind_b), .first_a(fa_b), .first_b(fb_b), .halt(halt_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model state
    logic [CH-1:0] m_sticky;
    int            m_cnt_a, m_cnt_b;
    bit            m_fv, m_kind, m_halt_a, m_halt_b;
    int            m_ch;
    logic [W-1:0]  m_fa, m_fb;
    int            run [CH];   // consecutive cycles each request has waited

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] cmpv, tmov, ev;
        if (!reset_n || clear) begin
            m_sticky = '0; m_cnt_a = 0; m_cnt_b = 0; m_fv = 0; m_ch = 0; m_kind = 0;
            m_fa = '0; m_fb = '0; m_halt_a = 0; m_halt_b = 0;
            for (int i = 0; i < CH; i++) run[i] = 0;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            cmpv[i] = chk_valid[i] && !chk_bypass[i] && (chk_a[i*W +: W] != chk_b[i*W +: W]);
            if (live_req[i] && !live_ack[i]) run[i]++;
            else run[i] = 0;
            tmov[i] = (run[i] == TMO);
        end
        ev = cmpv | tmov;
        m_sticky = m_sticky | ev;
        m_cnt_a = m_cnt_a + $countones(ev);
        if (m_cnt_a > (1 << CNT_A) - 1) m_cnt_a = (1 << CNT_A) - 1;
        m_cnt_b = m_cnt_b + $countones(ev);
        if (m_cnt_b > (1 << CNT_B) - 1) m_cnt_b = (1 << CNT_B) - 1;
        if (m_cnt_a >= MAXF_A) m_halt_a = 1;
        if (m_cnt_b >= MAXF_B) m_halt_b = 1;
        if (!m_fv && ev != '0) begin
            for (int i = 0; i < CH; i++) begin
                if (ev[i]) begin
                    m_fv   = 1;
                    m_ch   = i;
                    m_kind = !cmpv[i];
                    m_fa   = cmpv[i] ? chk_a[i*W +: W] : '0;
                    m_fb   = cmpv[i] ? chk_b[i*W +: W] : '0;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("a.sticky", 32'(sticky_a), 32'(m_sticky));
        check("a.count",  32'(count_a),  m_cnt_a);
        check("a.fvalid", 32'(fv_a),     32'(m_fv));
        check("a.fch",    32'(fch_a),    m_ch);
        check("a.fkind",  32'(kind_a),   32'(m_kind));
        check("a.fa",     32'(fa_a),     32'(m_fa));
        check("a.fb",     32'(fb_a),     32'(m_fb));
        check("a.halt",   32'(halt_a),   32'(m_halt_a));
        check("b.sticky", 32'(sticky_b), 32'(m_sticky));
        check("b.count",  32'(count_b),  m_cnt_b);
        check("b.fvalid", 32'(fv_b),     32'(m_fv));
        check("b.fch",    32'(fch_b),    m_ch);
        check("b.fkind",  32'(kind_b),   32'(m_kind));
        check("b.fa",     32'(fa_b),     32'(m_fa));
        check("b.fb",     32'(fb_b),     32'(m_fb));
        check("b.halt",   32'(halt_b),   32'(m_halt_b));
    endtask

    // Model advances on each edge; outputs compared just after it.
    always @(posedge clock) begin
        model_step();
        #1;
        compare_all();
    end

    task automatic idle();
        chk_valid = '0; chk_bypass = '0; chk_a = '0; chk_b = '0;
        live_req = '0; live_ack = '0; clear = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        logic [CH-1:0] rq;
        reset_n = 1'b0;
        idle();
        repeat (3) @(negedge clock);
        check("lit.reset_sticky", 32'(sticky_a), 0);
        check("lit.reset_count",  32'(count_a), 0);
        check("lit.reset_halt",   32'(halt_a), 0);
        check("lit.reset_fvalid", 32'(fv_a), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // ch2 mismatch 0x5A vs 0x5B
        chk_valid = 4'b0100; chk_a[2*W +: W] = 8'h5A; chk_b[2*W +: W] = 8'h5B;
        @(negedge clock);
        idle();
        check("lit.cmp_sticky", 32'(sticky_a), 32'h4);
        check("lit.cmp_count",  32'(count_a), 1);
        check("lit.cmp_fch",    32'(fch_a), 2);
        check("lit.cmp_kind",   32'(kind_a), 0);
        check("lit.cmp_fa",     32'(fa_a), 32'h5A);
        check("lit.cmp_fb",     32'(fb_a), 32'h5B);
        check("lit.cmp_halt",   32'(halt_a), 1);
        check("lit.cmp_halt_b", 32'(halt_b), 0);
        pulse_clear();
        check("lit.clear_count", 32'(count_a), 0);

        // waived mismatch, then matching operands: nothing recorded
        chk_valid = 4'b0100; chk_bypass = 4'b0100;
        chk_a[2*W +: W] = 8'h5A; chk_b[2*W +: W] = 8'h5B;
        repeat (10) @(negedge clock);
        chk_bypass = '0; chk_b[2*W +: W] = 8'h5A;
        repeat (10) @(negedge clock);
        idle();
        check("lit.quiet_sticky", 32'(sticky_a), 0);
        check("lit.quiet_count",  32'(count_a), 0);
        check("lit.quiet_fvalid", 32'(fv_a), 0);

        // ch0 request held without ack
        live_req = 4'b0001;
        repeat (15) @(negedge clock);
        check("lit.tmo_early", 32'(count_a), 0);
        @(negedge clock);
        check("lit.tmo_count", 32'(count_a), 1);
        check("lit.tmo_kind",  32'(kind_a), 1);
        check("lit.tmo_fch",   32'(fch_a), 0);
        check("lit.tmo_fa",    32'(fa_a), 0);
        check("lit.tmo_fb",    32'(fb_a), 0);
        repeat (40) @(negedge clock);
        check("lit.tmo_hold", 32'(count_a), 1);
        idle();
        pulse_clear();

        // ch1 and ch3 together, then ch0
        chk_valid = 4'b1010;
        chk_a[1*W +: W] = 8'h01; chk_b[1*W +: W] = 8'h02;
        chk_a[3*W +: W] = 8'h03; chk_b[3*W +: W] = 8'h04;
        @(negedge clock);
        idle();
        chk_valid = 4'b0001; chk_a[W-1:0] = 8'h07; chk_b[W-1:0] = 8'h08;
        @(negedge clock);
        idle();
        check("lit.multi_count",  32'(count_a), 3);
        check("lit.multi_fch",    32'(fch_a), 1);
        check("lit.multi_sticky", 32'(sticky_a), 32'hB);
        check("lit.multi_fa",     32'(fa_a), 32'h01);
        check("lit.multi_count_b", 32'(count_b), 3);
        chk_valid = 4'b0001; chk_a[W-1:0] = 8'h07; chk_b[W-1:0] = 8'h08;
        repeat (2) @(negedge clock);
        idle();
        check("lit.sat_count_a", 32'(count_a), 5);
        check("lit.sat_count_b", 32'(count_b), 3);
        check("lit.sat_halt_b",  32'(halt_b), 1);

        // clear wins over a coincident mismatch
        clear = 1'b1; chk_valid = 4'b0001; chk_a[W-1:0] = 8'h11; chk_b[W-1:0] = 8'h22;
        @(negedge clock);
        idle();
        check("lit.clrwin_sticky", 32'(sticky_a), 0);
        check("lit.clrwin_count",  32'(count_a), 0);
        check("lit.clrwin_fvalid", 32'(fv_a), 0);
        check("lit.clrwin_halt",   32'(halt_a), 0);

        // reset mid-timeout restarts the wait
        live_req = 4'b0001;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        check("lit.rst_tmo_early", 32'(count_a), 0);
        @(negedge clock);
        check("lit.rst_tmo_count", 32'(count_a), 1);
        check("lit.rst_tmo_kind",  32'(kind_a), 1);
        idle();
        pulse_clear();

        // randomized traffic
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                chk_valid[i]    = ($urandom_range(0, 5) == 0);
                chk_bypass[i]   = ($urandom_range(0, 3) == 0);
                chk_a[i*W +: W] = W'($urandom);
                chk_b[i*W +: W] = ($urandom_range(0, 1) == 0) ? chk_a[i*W +: W] : W'($urandom);
                if ($urandom_range(0, 19) == 0) rq[i] = ~rq[i];
                live_ack[i]     = ($urandom_range(0, 24) == 0);
            end
            live_req = rq;
            clear    = ($urandom_range(0, 49) == 0);
            reset_n  = ($urandom_range(0, 199) != 0);
            @(negedge clock);
        end
        idle();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sifive_assert_monitor.md
SIFIVE_ASSERT_MONITOR -- requirements
Module: sifive_assert_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent check channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, compared operand width per channel.
REQ-003 SHALL have parameter TIMEOUT, default 16, req-without-ack cycles before a liveness failure; 0 disables liveness checks.
REQ-004 SHALL have parameter MAX_FAILS, default 1, failure count that sets halt; 0 disables halt.
REQ-005 SHALL have parameter CNT_W, default 8, fail_count width.
REQ-006 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-008 SHALL have port chk_valid  input  CHANNELS  per-channel compare enable.
REQ-009 SHALL have port chk_bypass  input  CHANNELS  per-channel compare waiver.
REQ-010 SHALL have port chk_a  input  CHANNELS*WIDTH  packed operand A; channel i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port chk_b  input  CHANNELS*WIDTH  packed operand B, same packing.
REQ-012 SHALL have port live_req  input  CHANNELS  per-channel outstanding request.
REQ-013 SHALL have port live_ack  input  CHANNELS  per-channel acknowledge.
REQ-014 SHALL have port clear  input  1  synchronous clear of all recorded state.
REQ-015 SHALL have port fail_sticky  output  CHANNELS  per-channel sticky failure flag.
REQ-016 SHALL have port fail_count  output  CNT_W  saturating total failure count.
REQ-017 SHALL have port first_valid  output  1  first-failure record held.
REQ-018 SHALL have port first_ch  output  max(1,clog2(CHANNELS))  channel of first failure.
REQ-019 SHALL have port first_kind  output  1  0 = compare, 1 = timeout.
REQ-020 SHALL have ports first_a, first_b  output  WIDTH each  operands captured at first failure.
REQ-021 SHALL have port halt  output  1  sticky stop request.

Function
REQ-022 SHALL flag compare failure cmp_i = chk_valid[i] & ~chk_bypass[i] & (a_i != b_i), evaluated each cycle.
REQ-023 SHALL keep per-channel wait counter (TIMEOUT>0): increment while live_req[i] & ~live_ack[i]; zero when live_req low or live_ack high.
REQ-024 SHALL pulse tmo_i for exactly one cycle when the wait counter would reach TIMEOUT; counter then saturates at TIMEOUT, no re-fire until released per REQ-023.
REQ-025 SHALL define event_i = cmp_i | tmo_i; both on one channel in one cycle count as one event.
REQ-026 SHALL, at each edge, OR event vector into fail_sticky.
REQ-027 SHALL add popcount(event) to fail_count, saturating at 2^CNT_W-1 (no wrap).
REQ-028 SHALL, when first_valid=0 and any event, capture lowest-index event channel into first_ch, set first_valid; first_kind=0 if cmp on that channel, else 1.
REQ-029 SHALL capture first_a/first_b = that channel's chk_a/chk_b for kind 0, zero for kind 1; record frozen until clear/reset.
REQ-030 SHALL set halt (sticky) in the cycle the updated fail_count >= MAX_FAILS, when MAX_FAILS>0.
REQ-031 SHALL register all outputs; an event in cycle N is visible on outputs in cycle N+1.
REQ-032 SHALL, when clear=1, zero all outputs and wait counters; events in that cycle are discarded (clear wins).
REQ-033 SHALL, in simulation only, print one message and invoke fatal stop on halt rising edge, gated by the standard print/stop condition macros; no effect in synthesis.

Reset
REQ-034 SHALL, with reset_n=0 at a rising edge, zero fail_sticky, fail_count, first_*, halt and all wait counters; reset overrides clear and events.
REQ-035 SHALL resume checking on the first edge with reset_n=1; a mid-operation reset discards partial wait counts.

Verification
REQ-036 SHALL cover: ch2 valid, a=0x5A, b=0x5B, bypass=0 -> next cycle fail_sticky=0100, count=1, first_ch=2, kind=0, first_a=0x5A, first_b=0x5B, halt=1 (MAX_FAILS=1).
REQ-037 SHALL cover: same mismatch with bypass=1, or a==b -> no state change over 10 cycles.
REQ-038 SHALL cover: ch0 req high, ack low for 16 cycles (TIMEOUT=16) -> single tmo event, count=1, kind=1, first_a=first_b=0; held req 40 more cycles -> count stays 1.
REQ-039 SHALL cover: ch1 and ch3 mismatch same cycle, then ch0 mismatch -> count=3, first_ch=1, sticky=1011; CNT_W=2 with 5 events -> count=3.
REQ-040 SHALL cover: clear asserted coincident with ch0 mismatch -> all outputs zero next cycle; reset_n=0 mid-timeout at count 10 -> counter restarts, timeout fires 16 cycles after release.
